// File: rtl/fifo_sync_flags_pkg.sv
// Shared helpers for the UART/ALU datapath FIFOs: ceiling log2 used to size pointers.
package fifo_sync_flags_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_sync_flags_edge_detect.sv
// 1-bit registered rising-edge detector; o_rise is combinational, valid in the cycle i_sig first goes high.
// No reset on purpose: it keeps sampling through reset so a level held across reset release is not a new edge.
module edge_detect (
  input  logic i_clk,
  input  logic i_sig,
  output logic o_rise
);

  logic prev_q;

  always_ff @(posedge i_clk) begin
    prev_q <= i_sig;
  end

  assign o_rise = i_sig & ~prev_q;

endmodule

// File: rtl/fifo_sync_flags.sv
// Show-ahead synchronous FIFO with occupancy, almost thresholds and sticky overflow/underflow flags.
// Write-to-visible latency 1 cycle; writes while full are dropped (unless a read frees a slot) and flagged.
module fifo_sync_flags
  import fifo_sync_flags_pkg::*;
#(
  parameter int NB_WORD        = 8,
  parameter int N_WORD_BUFFER  = 16,
  parameter int N_ALMOST_FULL  = 12,
  parameter int N_ALMOST_EMPTY = 2,
  parameter bit WRITE_EDGE     = 1'b1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [NB_WORD-1:0]                     i_data,
  input  logic                                   i_write,
  input  logic                                   i_read,
  input  logic                                   i_clr_err,
  output logic [NB_WORD-1:0]                     o_data,
  output logic                                   o_fifo_empty,
  output logic                                   o_fifo_full,
  output logic                                   o_almost_full,
  output logic                                   o_almost_empty,
  output logic [clog2(N_WORD_BUFFER):0]          o_count,
  output logic                                   o_overflow,
  output logic                                   o_underflow
);

  localparam int NB_PTR = clog2(N_WORD_BUFFER);
  localparam logic [NB_PTR:0] AF_TH = (NB_PTR+1)'(N_ALMOST_FULL);
  localparam logic [NB_PTR:0] AE_TH = (NB_PTR+1)'(N_ALMOST_EMPTY);

  logic [NB_WORD-1:0] mem_q [N_WORD_BUFFER];
  logic [NB_PTR:0]    wr_ptr_q, wr_ptr_d;
  logic [NB_PTR:0]    rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               wr_req;
  logic               wr_acc;
  logic               rd_acc;
  logic               empty;
  logic               full;
  logic [NB_PTR:0]    count;

  generate
    if (WRITE_EDGE) begin : g_edge
      edge_detect u_edge_detect (
        .i_clk  (i_clk),
        .i_sig  (i_write),
        .o_rise (wr_req)
      );
    end else begin : g_level
      assign wr_req = i_write;
    end
  endgenerate

  // Wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[NB_PTR-1:0] == rd_ptr_q[NB_PTR-1:0]) &&
                 (wr_ptr_q[NB_PTR] != rd_ptr_q[NB_PTR]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign rd_acc = i_read & ~empty;
  assign wr_acc = wr_req & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q & ~i_clr_err;
    underflow_d = underflow_q & ~i_clr_err;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    // A new error event takes priority over a clear in the same cycle.
    if (wr_req && full && !rd_acc) overflow_d = 1'b1;
    if (i_read && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc && !i_rst) mem_q[wr_ptr_q[NB_PTR-1:0]] <= i_data;
  end

  assign o_data         = mem_q[rd_ptr_q[NB_PTR-1:0]];
  assign o_fifo_empty   = empty;
  assign o_fifo_full    = full;
  assign o_almost_full  = (count >= AF_TH);
  assign o_almost_empty = (count <= AE_TH);
  assign o_count        = count;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: edge-strobed FIFO (defaults) plus a level-write twin sharing the same stimulus.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       wr;
  logic       rd;
  logic       clr;

  logic [7:0] dout, dout_l;
  logic       empty, full, afull, aempty, ovf, unf;
  logic       empty_l, full_l, afull_l, aempty_l, ovf_l, unf_l;
  logic [4:0] cnt, cnt_l;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.WRITE_EDGE(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_write(wr), .i_read(rd), .i_clr_err(clr),
    .o_data(dout), .o_fifo_empty(empty), .o_fifo_full(full), .o_almost_full(afull),
    .o_almost_empty(aempty), .o_count(cnt), .o_overflow(ovf), .o_underflow(unf)
  );

  fifo_sync_flags #(.WRITE_EDGE(1'b0)) dut_lvl (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_write(wr), .i_read(rd), .i_clr_err(clr),
    .o_data(dout_l), .o_fifo_empty(empty_l), .o_fifo_full(full_l), .o_almost_full(afull_l),
    .o_almost_empty(aempty_l), .o_count(cnt_l), .o_overflow(ovf_l), .o_underflow(unf_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = 8'h00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d);
    din = d; wr = 1'b1;
    tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (cnt !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", cnt); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_vec++; if (aempty !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b want 1", aempty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_vec++; if (afull !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", afull); end
    n_vec++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL reset_err got ovf=%b unf=%b want 0 0", ovf, unf); end
  endtask

  task automatic test_strobes();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      strobe(8'hA1 + 8'(i));
      n_vec++; if (cnt !== 5'(i + 1)) begin n_err++; $display("FAIL strobe_count[%0d] got %0d want %0d", i, cnt, i + 1); end
      n_vec++; if (aempty !== (i + 1 <= 2)) begin n_err++; $display("FAIL strobe_aempty[%0d] got %b want %b", i, aempty, (i + 1 <= 2)); end
    end
    n_vec++; if (dout !== 8'hA1) begin n_err++; $display("FAIL strobe_head got %h want a1", dout); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL strobe_empty got %b want 0", empty); end
  endtask

  task automatic test_level_vs_edge();
    do_reset();
    din = 8'h30; wr = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    wr = 1'b0;
    n_vec++; if (cnt !== 5'd1) begin n_err++; $display("FAIL held_edge_count got %0d want 1", cnt); end
    n_vec++; if (cnt_l !== 5'd5) begin n_err++; $display("FAIL held_level_count got %0d want 5", cnt_l); end
    tick();
    // Write held high across reset release must not produce a write in edge mode.
    rst = 1'b1; wr = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    n_vec++; if (cnt !== 5'd0) begin n_err++; $display("FAIL across_reset_count got %0d want 0", cnt); end
    wr = 1'b0;
    tick();
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      strobe(8'(i));
      n_vec++; if (cnt !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, cnt, i + 1); end
      n_vec++; if (afull !== (i + 1 >= 12)) begin n_err++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull, (i + 1 >= 12)); end
      n_vec++; if (full !== (i == 15)) begin n_err++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 15)); end
    end
    strobe(8'hEE);
    n_vec++; if (cnt !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d want 16", cnt); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ovf); end
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (dout !== 8'(i)) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, dout, 8'(i)); end
      tick();
    end
    rd = 1'b0;
    n_vec++; if (empty !== 1'b1 || unf !== 1'b0) begin n_err++; $display("FAIL drain_end got empty=%b unf=%b want 1 0", empty, unf); end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 16; i++) strobe(8'(i));
    din = 8'h55; wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    n_vec++; if (cnt !== 5'd16) begin n_err++; $display("FAIL full_rw_count got %0d want 16", cnt); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL full_rw_ovf got %b want 0", ovf); end
    rd = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if (dout !== ((k < 15) ? 8'(k + 1) : 8'h55)) begin
        n_err++; $display("FAIL full_rw_data[%0d] got %h want %h", k, dout, ((k < 15) ? 8'(k + 1) : 8'h55));
      end
      tick();
    end
    rd = 1'b0;
    n_vec++; if (cnt !== 5'd0) begin n_err++; $display("FAIL full_rw_end_count got %0d want 0", cnt); end
  endtask

  task automatic test_underflow();
    do_reset();
    rd = 1'b1; tick(); rd = 1'b0;
    n_vec++; if (unf !== 1'b1 || cnt !== 5'd0) begin n_err++; $display("FAIL unf_set got unf=%b cnt=%0d want 1 0", unf, cnt); end
    clr = 1'b1; tick(); clr = 1'b0;
    n_vec++; if (unf !== 1'b0) begin n_err++; $display("FAIL unf_clear got %b want 0", unf); end
    din = 8'h77; wr = 1'b1; rd = 1'b1; tick(); wr = 1'b0; rd = 1'b0;
    n_vec++; if (cnt !== 5'd1 || dout !== 8'h77) begin n_err++; $display("FAIL empty_rw got cnt=%0d data=%h want 1 77", cnt, dout); end
    n_vec++; if (unf !== 1'b1) begin n_err++; $display("FAIL empty_rw_unf got %b want 1", unf); end
    rd = 1'b1; tick();
    clr = 1'b1; tick(); rd = 1'b0; clr = 1'b0;
    n_vec++; if (unf !== 1'b1) begin n_err++; $display("FAIL set_beats_clear got %b want 1", unf); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      din = 8'h80 + 8'(i); wr = 1'b1;
      tick();
      wr = 1'b0; rd = 1'b1;
      n_vec++; if (dout !== 8'h80 + 8'(i)) begin n_err++; $display("FAIL wrap_data[%0d] got %h want %h", i, dout, 8'h80 + 8'(i)); end
      tick();
      rd = 1'b0;
    end
    n_vec++; if (cnt !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL wrap_end got cnt=%0d empty=%b want 0 1", cnt, empty); end
    rd = 1'b1; tick(); rd = 1'b0;
    for (int i = 0; i < 3; i++) strobe(8'hC0 + 8'(i));
    n_vec++; if (cnt !== 5'd3 || unf !== 1'b1 || dout !== 8'hC0) begin n_err++; $display("FAIL pre_reset got cnt=%0d unf=%b data=%h want 3 1 c0", cnt, unf, dout); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_vec++; if (cnt !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL post_reset got cnt=%0d empty=%b want 0 1", cnt, empty); end
    n_vec++; if (unf !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL post_reset_err got unf=%b ovf=%b want 0 0", unf, ovf); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = 8'h00;
    test_reset();
    test_strobes();
    test_level_vs_edge();
    test_fill_overflow();
    test_full_rw();
    test_underflow();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised synchronous FIFO that succeeds the existing single-clock FIFO in the UART/ALU datapath. It keeps show-ahead read and wrap-bit full/empty detection. It adds:
- an occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a selectable write mode: edge-strobed or level, one word per cycle

It buffers bytes between the UART receiver/transmitter and the interface controller.

Parameters:
NB_WORD, 8, data word width in bits (>=1)
N_WORD_BUFFER, 16, depth in words; power of two, >=2
N_ALMOST_FULL, 12, o_almost_full asserted when count >= this value (1..N_WORD_BUFFER)
N_ALMOST_EMPTY, 2, o_almost_empty asserted when count <= this value (0..N_WORD_BUFFER-1)
WRITE_EDGE, 1, 1: a write is accepted only on a rising edge of i_write; 0: a write is accepted every cycle i_write is high

Ports:
i_clk  in  1  clock; all state updates on its rising edge
i_rst  in  1  synchronous, active-high reset
i_data  in  NB_WORD  write data
i_write  in  1  write request (strobe or level, per WRITE_EDGE)
i_read  in  1  read/advance request; pops the word currently on o_data
i_clr_err  in  1  clears o_overflow and o_underflow
o_data  out  NB_WORD  head word, combinational from storage (show-ahead)
o_fifo_empty  out  1  count == 0
o_fifo_full  out  1  count == N_WORD_BUFFER
o_almost_full  out  1  count >= N_ALMOST_FULL
o_almost_empty  out  1  count <= N_ALMOST_EMPTY
o_count  out  clog2(N_WORD_BUFFER)+1  occupancy, 0..N_WORD_BUFFER
o_overflow  out  1  sticky: a write was attempted while full with no simultaneous read
o_underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Pointers: rd_ptr and wr_ptr, each clog2(N_WORD_BUFFER)+1 bits (address plus wrap bit).
  - empty: pointers are equal.
  - full: addresses are equal and wrap bits differ.
  - o_count = wr_ptr - rd_ptr, modulo 2^(NB_PTR+1).
- Reset (i_rst=1 at a clock edge): both pointers return to 0 and both error flags clear.
  - Post-reset outputs: o_fifo_empty=1, o_almost_empty=1, o_fifo_full=0, o_almost_full=0, o_count=0, o_overflow=0, o_underflow=0.
  - Storage is not cleared. o_data is don't-care whenever empty.
- Write-edge register (WRITE_EDGE=1):
  - Samples i_write every cycle, including during reset.
  - A write request is i_write & ~prev.
  - i_write held high across reset release therefore produces no write.
- Accepted write: the request is valid and (not full, or a read is accepted in the same cycle). Storage[wr addr] <= i_data; wr_ptr increments.
- Accepted read: i_read=1 and not empty. rd_ptr increments; the next word appears on o_data in the following cycle.
- Latency: a word written at edge N is visible on o_data and counted after edge N, i.e. in cycle N+1.
- Simultaneous read and write:
  - Not empty: both are accepted; count is unchanged.
  - Full: both are accepted; no overflow.
  - Empty: only the write is accepted; underflow is set.
- Write request while full and no accepted read: word dropped, pointers unchanged, o_overflow <= 1.
- i_read while empty: pointers unchanged, o_underflow <= 1.
- Error flags:
  - Cleared by i_clr_err or i_rst.
  - A set event in the same cycle as i_clr_err wins, so the flag stays 1.
- Wrap-around: address bits wrap naturally at N_WORD_BUFFER; the wrap bit toggles.
- All flags and o_count are combinational from the pointer registers. No extra latency beyond the pointer update.
- No state machine beyond the pointers, the edge register and the two sticky flags.

Decomposition:
- Shared package/header: the existing clog2 function, plus the derived localparam NB_PTR = clog2(N_WORD_BUFFER) computed in-module from it.
- No typedefs needed.
- One natural sub-module: edge_detect, a 1-bit registered rising-edge detector. It is also reusable for the ALU/UART button strobes. It is instantiated only when WRITE_EDGE=1; otherwise i_write is used directly.
- Storage stays inline as a register array.

Test Plan:
- Reset, then 4 single-cycle write strobes of 0xA1..0xA4 (WRITE_EDGE=1, defaults) -> o_count=4, o_data=0xA1, o_almost_empty=0, o_fifo_empty=0.
- i_write held high for 5 cycles (WRITE_EDGE=1) -> exactly 1 word stored; the same stimulus with WRITE_EDGE=0 -> 5 words stored.
- Fill 16 words with 0x00..0x0F -> o_almost_full rises when count reaches 12; o_fifo_full=1 at 16. A 17th write -> count stays 16, o_overflow=1. Reads then return 0x00..0x0F in order.
- At full, read and write 0x55 in the same cycle -> count stays 16, o_overflow=0. After 16 further reads, the last word read is 0x55.
- From empty, i_read=1 -> o_underflow=1, count=0. i_clr_err=1 for one cycle -> o_underflow=0. Empty with read and write of 0x77 together -> count=1, o_data=0x77, o_underflow=1.
- Write 20 and read 20 interleaved (wrap-around), then assert i_rst with count=3 -> next cycle o_count=0, o_fifo_empty=1, flags cleared.
